// File: rtl/sram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : sram_port_arbiter_if
// Description : Bundle of the requester and SRAM-side signals of the
//               two-port SRAM arbiter. Per-port request fields are packed
//               side by side, port p occupying [p*W +: W].
//   req_valid_i / req_ready_o / req_lock_i / req_we_i : per-port handshake
//   req_addr_i / req_wdata_i / req_wmask_i            : per-port command
//   rsp_valid_o / rsp_rdata_o                         : per-port response
//   mem_csb_o / mem_web_o / mem_wmask_o / mem_addr_o /
//   mem_wdata_o / mem_rdata_i                         : SRAM macro pins
//   Modports: slave  = arbiter side
//             master = requesters plus SRAM macro (environment side)
// Revision    : 1.0 - initial release
// ============================================================================
interface sram_port_arbiter_if #(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 32,
    parameter int NUM_WMASKS = 4
);
    logic [1:0]              req_valid_i;
    logic [1:0]              req_ready_o;
    logic [1:0]              req_lock_i;
    logic [2*ADDR_W-1:0]     req_addr_i;
    logic [2*DATA_W-1:0]     req_wdata_i;
    logic [2*NUM_WMASKS-1:0] req_wmask_i;
    logic [1:0]              req_we_i;
    logic [1:0]              rsp_valid_o;
    logic [DATA_W-1:0]       rsp_rdata_o;
    logic                    mem_csb_o;
    logic                    mem_web_o;
    logic [NUM_WMASKS-1:0]   mem_wmask_o;
    logic [ADDR_W-1:0]       mem_addr_o;
    logic [DATA_W-1:0]       mem_wdata_o;
    logic [DATA_W-1:0]       mem_rdata_i;

    modport slave (
        input  req_valid_i, req_lock_i, req_addr_i, req_wdata_i, req_wmask_i,
               req_we_i, mem_rdata_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, mem_csb_o, mem_web_o,
               mem_wmask_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output req_valid_i, req_lock_i, req_addr_i, req_wdata_i, req_wmask_i,
               req_we_i, mem_rdata_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, mem_csb_o, mem_web_o,
               mem_wmask_o, mem_addr_o, mem_wdata_o
    );
endinterface
`default_nettype wire

// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_port_arbiter
// Description : Shares one single-port SRAM macro between an instruction
//               fetch port (0) and a load/store port (1). Round-robin
//               arbitration with an optional bounded lock, registered SRAM
//               command pins and in-order response routing via a tag pipe.
// Ports       :
//   clk_i   in  clock
//   rst_ni  in  asynchronous reset, active low
//   bus     slave modport of sram_port_arbiter_if (requests, responses and
//           SRAM pins)
// Revision    : 1.0 - initial release
// ============================================================================
module sram_port_arbiter #(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 32,
    parameter int NUM_WMASKS = 4,
    parameter int RD_LATENCY = 1,
    parameter int MAX_LOCK   = 16
) (
    input  wire logic          clk_i,
    input  wire logic          rst_ni,
    sram_port_arbiter_if.slave bus
);

    localparam int                 c_cnt_w    = $clog2(MAX_LOCK + 1);
    localparam logic [c_cnt_w-1:0] c_max_lock = c_cnt_w'(MAX_LOCK);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    typedef enum logic [0:0] {
        c_unlocked = 1'b0,
        c_locked   = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_lock_port;
    logic                 w_lock_port_nxt;
    logic [c_cnt_w-1:0]   r_lock_cnt;
    logic [c_cnt_w-1:0]   w_lock_cnt_nxt;
    logic                 r_rr_ptr;
    logic                 w_rr_ptr_nxt;

    logic                 w_gnt_vld;
    logic                 w_gnt_port;
    logic [1:0]           w_ready;
    logic                 w_force;

    logic                 r_csb;
    logic                 r_web;
    logic [NUM_WMASKS-1:0] r_wmask;
    logic [ADDR_W-1:0]    r_addr;
    logic [DATA_W-1:0]    r_wdata;

    // Tag pipe: stage k holds the beat issued k+1 cycles ago.
    logic [RD_LATENCY:0]  r_tag_vld;
    logic [RD_LATENCY:0]  r_tag_port;

    // The lock holder has used up its budget while the other port waits:
    // leave a one-cycle gap and point rr_ptr at the waiting port so it wins
    // the next arbitration.
    assign w_force = (r_state == c_locked) && (r_lock_cnt == c_max_lock)
                     && bus.req_valid_i[!r_lock_port];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= c_unlocked;
            r_lock_port <= 1'b0;
            r_lock_cnt  <= '0;
            r_rr_ptr    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_lock_port <= w_lock_port_nxt;
            r_lock_cnt  <= w_lock_cnt_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
        end
    end

    always_comb begin
        w_gnt_vld       = 1'b0;
        w_gnt_port      = 1'b0;
        w_ready         = 2'b00;
        w_state_nxt     = r_state;
        w_lock_port_nxt = r_lock_port;
        w_lock_cnt_nxt  = r_lock_cnt;
        w_rr_ptr_nxt    = r_rr_ptr;

        if (w_force) begin
            w_gnt_vld = 1'b0;
        end else if ((r_state == c_locked) && bus.req_valid_i[r_lock_port]) begin
            w_gnt_vld  = 1'b1;
            w_gnt_port = r_lock_port;
        end else if (&bus.req_valid_i) begin
            w_gnt_vld  = 1'b1;
            w_gnt_port = r_rr_ptr;
        end else if (bus.req_valid_i[0]) begin
            w_gnt_vld  = 1'b1;
            w_gnt_port = 1'b0;
        end else if (bus.req_valid_i[1]) begin
            w_gnt_vld  = 1'b1;
            w_gnt_port = 1'b1;
        end

        if (w_gnt_vld) begin
            w_ready[w_gnt_port] = 1'b1;
            w_rr_ptr_nxt        = !w_gnt_port;
            if (bus.req_lock_i[w_gnt_port]) begin
                w_state_nxt     = c_locked;
                w_lock_port_nxt = w_gnt_port;
                // Continuing an existing lock counts up (saturating); a new
                // lock holder starts at one.
                if ((r_state == c_locked) && (r_lock_port == w_gnt_port)) begin
                    w_lock_cnt_nxt = (r_lock_cnt == c_max_lock) ? r_lock_cnt
                                                                : r_lock_cnt + c_cnt_one;
                end else begin
                    w_lock_cnt_nxt = c_cnt_one;
                end
            end else begin
                w_state_nxt    = c_unlocked;
                w_lock_cnt_nxt = '0;
            end
        end else if (r_state == c_locked) begin
            // Lock holder dropped valid, or forced rotation.
            w_state_nxt    = c_unlocked;
            w_lock_cnt_nxt = '0;
            if (w_force) begin
                w_rr_ptr_nxt = !r_lock_port;
            end
        end
    end

    // SRAM command register; address and data hold while idle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_csb   <= 1'b1;
            r_web   <= 1'b1;
            r_wmask <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_gnt_vld) begin
            r_csb   <= 1'b0;
            r_web   <= !bus.req_we_i[w_gnt_port];
            r_wmask <= bus.req_wmask_i[w_gnt_port*NUM_WMASKS +: NUM_WMASKS];
            r_addr  <= bus.req_addr_i[w_gnt_port*ADDR_W +: ADDR_W];
            r_wdata <= bus.req_wdata_i[w_gnt_port*DATA_W +: DATA_W];
        end else begin
            r_csb   <= 1'b1;
            r_web   <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tag_vld  <= '0;
            r_tag_port <= '0;
        end else begin
            r_tag_vld  <= {r_tag_vld[RD_LATENCY-1:0], w_gnt_vld};
            r_tag_port <= {r_tag_port[RD_LATENCY-1:0], w_gnt_port};
        end
    end

    assign bus.req_ready_o = w_ready;
    assign bus.mem_csb_o   = r_csb;
    assign bus.mem_web_o   = r_web;
    assign bus.mem_wmask_o = r_wmask;
    assign bus.mem_addr_o  = r_addr;
    assign bus.mem_wdata_o = r_wdata;
    assign bus.rsp_valid_o = !r_tag_vld[RD_LATENCY] ? 2'b00
                           : (r_tag_port[RD_LATENCY] ? 2'b10 : 2'b01);
    assign bus.rsp_rdata_o = bus.mem_rdata_i;

endmodule
`default_nettype wire
